// File: rtl/seg_readback_decoder.sv
// Recovers the signed 3-bit value shown on the 8-bit seven-segment bus.
// A pattern is classified only after it has held for STABLE_CYCLES consecutive samples.
module seg_readback_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic [7:0]       seg_in,
  input  logic             sample_en,
  input  logic             cont,
  output logic [2:0]       value,
  output logic             valid,
  output logic             error,
  output logic             blank,
  output logic             busy,
  output logic [CNT_W-1:0] decode_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MONITOR = 2'd2
  } state_t;

  localparam logic [8:0] STABLE_LIM = 9'(STABLE_CYCLES);
  localparam logic [1:0] CLS_VALID  = 2'd0;
  localparam logic [1:0] CLS_ERROR  = 2'd1;
  localparam logic [1:0] CLS_BLANK  = 2'd2;

  generate
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_stable
      $error("seg_readback_decoder: STABLE_CYCLES must be within 2..255");
    end
  endgenerate

  // Returns {class[1:0], value[2:0]} for a segment pattern.
  function automatic logic [4:0] decode_seg(input logic [7:0] pat);
    logic [4:0] res;
    case (pat)
      8'h3F:   res = {CLS_VALID, 3'b000};
      8'h06:   res = {CLS_VALID, 3'b001};
      8'h5B:   res = {CLS_VALID, 3'b010};
      8'h4F:   res = {CLS_VALID, 3'b011};
      8'h86:   res = {CLS_VALID, 3'b111};
      8'hDB:   res = {CLS_VALID, 3'b110};
      8'hCF:   res = {CLS_VALID, 3'b101};
      8'hE6:   res = {CLS_VALID, 3'b100};
      8'h00:   res = {CLS_BLANK, 3'b000};
      default: res = {CLS_ERROR, 3'b000};
    endcase
    return res;
  endfunction

  state_t           state_r, state_n;
  logic [7:0]       shadow_r, shadow_n;
  logic [7:0]       run_r, run_n;
  logic             mode_r, mode_n;
  logic [2:0]       value_r, value_n;
  logic             valid_r, valid_n;
  logic             error_r, error_n;
  logic             blank_r, blank_n;
  logic             busy_r, busy_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [8:0]       run_inc_s;
  logic [4:0]       dec_s;
  logic             fire_s;

  assign run_inc_s = {1'b0, run_r} + 9'd1;
  assign dec_s     = decode_seg(shadow_r);

  // Next-state, stability counting and output event computation.
  always_comb begin
    state_n  = state_r;
    shadow_n = shadow_r;
    run_n    = run_r;
    mode_n   = mode_r;
    fire_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sample_en) begin
          shadow_n = seg_in;
          run_n    = 8'd1;
          mode_n   = cont;
          state_n  = ST_SETTLE;
        end else begin
          state_n  = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (seg_in != shadow_r) begin
          shadow_n = seg_in;
          run_n    = 8'd1;
        end else begin
          run_n = run_inc_s[7:0];
          if (run_inc_s == STABLE_LIM) begin
            fire_s  = 1'b1;
            state_n = mode_r ? ST_MONITOR : ST_IDLE;
          end else begin
            fire_s  = 1'b0;
          end
        end
      end
      ST_MONITOR: begin
        // Dropping cont wins over a simultaneous pattern change.
        if (!cont) begin
          state_n = ST_IDLE;
        end else if (seg_in != shadow_r) begin
          shadow_n = seg_in;
          run_n    = 8'd1;
          state_n  = ST_SETTLE;
        end else begin
          state_n  = ST_MONITOR;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    valid_n = 1'b0;
    error_n = 1'b0;
    value_n = value_r;
    blank_n = blank_r;
    cnt_n   = cnt_r;
    busy_n  = (state_n != ST_IDLE);
    if (fire_s) begin
      case (dec_s[4:3])
        CLS_VALID: begin
          valid_n = 1'b1;
          value_n = dec_s[2:0];
          cnt_n   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          blank_n = 1'b0;
        end
        CLS_ERROR: begin
          error_n = 1'b1;
          blank_n = 1'b0;
        end
        CLS_BLANK: begin
          blank_n = 1'b1;
        end
        default: begin
          blank_n = blank_r;
        end
      endcase
    end else begin
      blank_n = blank_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      shadow_r <= 8'h00;
      run_r    <= 8'd0;
      mode_r   <= 1'b0;
      value_r  <= 3'b000;
      valid_r  <= 1'b0;
      error_r  <= 1'b0;
      blank_r  <= 1'b0;
      busy_r   <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_n;
      shadow_r <= shadow_n;
      run_r    <= run_n;
      mode_r   <= mode_n;
      value_r  <= value_n;
      valid_r  <= valid_n;
      error_r  <= error_n;
      blank_r  <= blank_n;
      busy_r   <= busy_n;
      cnt_r    <= cnt_n;
    end
  end

  assign value      = value_r;
  assign valid      = valid_r;
  assign error      = error_r;
  assign blank      = blank_r;
  assign busy       = busy_r;
  assign decode_cnt = cnt_r;

endmodule

// File: tb/tb_seg_readback_decoder.sv
// Bench for seg_readback_decoder: directed scenarios plus randomized traffic,
// compared every cycle against a table-driven behavioural model.
module tb_seg_readback_decoder;

  localparam int STABLE = 4;

  logic       clk_2     = 1'b0;
  logic       reset_n   = 1'b0;
  logic [7:0] seg_in    = 8'h00;
  logic       sample_en = 1'b0;
  logic       cont      = 1'b0;
  logic [2:0] value;
  logic       valid;
  logic       error;
  logic       blank;
  logic       busy;
  logic [7:0] decode_cnt;

  seg_readback_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
    .clk_2      (clk_2),
    .reset_n    (reset_n),
    .seg_in     (seg_in),
    .sample_en  (sample_en),
    .cont       (cont),
    .value      (value),
    .valid      (valid),
    .error      (error),
    .blank      (blank),
    .busy       (busy),
    .decode_cnt (decode_cnt)
  );

  always #5 clk_2 = ~clk_2;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_seen = 0;
  int error_seen = 0;

  int         tbl[logic [7:0]];
  logic [7:0] pats[8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h86, 8'hDB, 8'hCF, 8'hE6};

  // Model: activity phase (0 idle, 1 settling, 2 watching), pattern held and its age.
  int         m_phase;
  logic [7:0] m_pat;
  int         m_age;
  logic       m_mode;
  logic [2:0] e_value;
  logic       e_valid, e_error, e_blank, e_busy;
  int         e_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_pat = 8'h00; m_age = 0; m_mode = 1'b0;
    e_value = 3'b000; e_valid = 1'b0; e_error = 1'b0;
    e_blank = 1'b0; e_busy = 1'b0; e_cnt = 0;
  endtask

  task automatic model_edge();
    e_valid = 1'b0;
    e_error = 1'b0;
    if (m_phase == 0) begin
      if (sample_en) begin
        m_pat = seg_in; m_age = 1; m_mode = cont; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (seg_in != m_pat) begin
        m_pat = seg_in; m_age = 1;
      end else begin
        m_age++;
        if (m_age == STABLE) begin
          if (tbl.exists(m_pat)) begin
            e_valid = 1'b1;
            e_value = 3'(tbl[m_pat]);
            e_cnt   = (e_cnt + 1) % 256;
            e_blank = 1'b0;
          end else if (m_pat == 8'h00) begin
            e_blank = 1'b1;
          end else begin
            e_error = 1'b1;
            e_blank = 1'b0;
          end
          m_phase = m_mode ? 2 : 0;
        end
      end
    end else begin
      if (!cont) m_phase = 0;
      else if (seg_in != m_pat) begin
        m_pat = seg_in; m_age = 1; m_phase = 1;
      end
    end
    e_busy = (m_phase != 0);
  endtask

  task automatic compare_all();
    check("value", 32'(value), 32'(e_value));
    check("valid", 32'(valid), 32'(e_valid));
    check("error", 32'(error), 32'(e_error));
    check("blank", 32'(blank), 32'(e_blank));
    check("busy", 32'(busy), 32'(e_busy));
    check("decode_cnt", 32'(decode_cnt), 32'(e_cnt));
  endtask

  task automatic step();
    @(posedge clk_2);
    if (!reset_n) model_reset();
    else model_edge();
    #1;
    compare_all();
    if (valid === 1'b1) valid_seen++;
    if (error === 1'b1) error_seen++;
  endtask

  initial begin
    int vs, es, idx, hold, sel;
    tbl[8'h3F] = 0;  tbl[8'h06] = 1;  tbl[8'h5B] = 2;  tbl[8'h4F] = 3;
    tbl[8'h86] = -1; tbl[8'hDB] = -2; tbl[8'hCF] = -3; tbl[8'hE6] = -4;
    model_reset();
    step(); step();
    check("reset_value", 32'(value), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_cnt", 32'(decode_cnt), 32'd0);
    reset_n = 1'b1;
    step();

    // Single decode of 0x5B: pulse three edges after the sampling edge.
    seg_in = 8'h5B; sample_en = 1'b1; step(); sample_en = 1'b0;
    step(); step(); step();
    check("s1_valid", 32'(valid), 32'd1);
    check("s1_value", 32'(value), 32'(3'b010));
    check("s1_cnt", 32'(decode_cnt), 32'd1);
    check("s1_busy", 32'(busy), 32'd0);
    step();
    check("s1_valid_drop", 32'(valid), 32'd0);

    // Glitch restarts the count.
    vs = valid_seen;
    seg_in = 8'hE6; sample_en = 1'b1; step(); sample_en = 1'b0;
    step(); step();
    seg_in = 8'h4F; step(); step();
    seg_in = 8'hE6;
    for (int i = 0; i < 6; i++) step();
    check("s2_value", 32'(value), 32'(3'b100));
    check("s2_pulses", 32'(valid_seen - vs), 32'd1);

    // Unknown pattern, then blank.
    vs = valid_seen; es = error_seen;
    seg_in = 8'h77; sample_en = 1'b1; step(); sample_en = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("s3_err_pulses", 32'(error_seen - es), 32'd1);
    check("s3_value_kept", 32'(value), 32'(3'b100));
    check("s3_cnt", 32'(decode_cnt), 32'd2);
    seg_in = 8'h00; sample_en = 1'b1; step(); sample_en = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("s3_blank", 32'(blank), 32'd1);
    check("s3_no_valid", 32'(valid_seen - vs), 32'd0);

    // Continuous monitoring.
    vs = valid_seen;
    cont = 1'b1; seg_in = 8'h3F; sample_en = 1'b1; step(); sample_en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    seg_in = 8'h06; for (int i = 0; i < 6; i++) step();
    seg_in = 8'h06; for (int i = 0; i < 6; i++) step();
    seg_in = 8'hCF; for (int i = 0; i < 6; i++) step();
    check("s4_pulses", 32'(valid_seen - vs), 32'd3);
    check("s4_cnt", 32'(decode_cnt), 32'd5);
    check("s4_value", 32'(value), 32'(3'b101));
    check("s4_busy", 32'(busy), 32'd1);
    cont = 1'b0; step();
    check("s4_idle", 32'(busy), 32'd0);

    // Asynchronous reset while settling.
    vs = valid_seen;
    seg_in = 8'h3F; sample_en = 1'b1; step(); sample_en = 1'b0; step();
    reset_n = 1'b0; #1;
    model_reset();
    check("s5_value", 32'(value), 32'd0);
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_cnt", 32'(decode_cnt), 32'd0);
    check("s5_blank", 32'(blank), 32'd0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("s5_no_pulse", 32'(valid_seen - vs), 32'd0);
    seg_in = 8'h86; sample_en = 1'b1; step(); sample_en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("s5_resume", 32'(valid_seen - vs), 32'd1);
    check("s5_value_m1", 32'(value), 32'(3'b111));

    // 256 decodes from zero wrap the counter; sample_en noise while busy.
    reset_n = 1'b0; #1; model_reset(); step(); reset_n = 1'b1; step();
    vs = valid_seen; idx = 0; cont = 1'b1;
    for (int d = 0; d < 256; d++) begin
      if (d > 0) begin
        sel = $urandom_range(0, 7);
        if (sel == idx) sel = (sel + 1) % 8;
        idx = sel;
      end
      seg_in = pats[idx];
      if (d == 0) sample_en = 1'b1;
      hold = $urandom_range(4, 7);
      for (int k = 0; k < hold; k++) begin
        step();
        sample_en = ($urandom_range(0, 3) == 0);
      end
      sample_en = 1'b0;
    end
    check("s6_pulses", 32'(valid_seen - vs), 32'd256);
    check("s6_wrap", 32'(decode_cnt), 32'd0);

    // Random traffic with transients, blanks, junk patterns and mode changes.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        sel = $urandom_range(0, 9);
        if (sel < 7) seg_in = pats[$urandom_range(0, 7)];
        else if (sel == 7) seg_in = 8'h00;
        else seg_in = 8'($urandom);
      end
      cont = ($urandom_range(0, 15) != 0);
      sample_en = ($urandom_range(0, 3) == 0);
      step();
    end
    sample_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_readback_decoder.md
Name: seg_readback_decoder

Overview:
- Inverse of the board's signed 3-bit ALU display path: it watches the 8-bit seven-segment bus and recovers the signed value shown.
- Bit 7 of the bus is the minus-sign segment; bits 6:0 are the digit.
- Before decoding, the bus must hold one pattern for a fixed number of clock cycles. This filters switch/ALU transients.
- Used for self-check of the display path and for driving the LCD debug fields from what is actually displayed.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical samples required before decoding; legal range 2..255, elaboration error otherwise.
- CNT_W, 8, width of the decode event counter.

Ports:
- clk_2  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- seg_in  input  8  seven-segment pattern under observation.
- sample_en  input  1  request one stable decode; honoured only in IDLE.
- cont  input  1  continuous-monitor mode select.
- value  output  3  signed decoded value, -4..3; holds its last good decode.
- valid  output  1  one-cycle pulse when value is updated.
- error  output  1  one-cycle pulse when a stable pattern is not in the table.
- blank  output  1  level; the last stable pattern was 8'h00.
- busy  output  1  high whenever state is not IDLE.
- decode_cnt  output  CNT_W  count of valid pulses; wraps.

Behaviour:
- Decode table (pattern -> value):
  - 0x3F -> 0, 0x06 -> 1, 0x5B -> 2, 0x4F -> 3
  - 0x86 -> -1, 0xDB -> -2, 0xCF -> -3, 0xE6 -> -4
- Pattern classes:
  - 0x00 is blank: no valid, no error, blank=1.
  - Any other pattern is an error.
  - A successful decode or an error clears blank.
- Reset (async assert, sync deassert):
  - state=IDLE, shadow=0x00, run=0.
  - value=0, valid=0, error=0, blank=0, busy=0, decode_cnt=0.
  - Reset mid-SETTLE aborts; no pulse is emitted.
- States: IDLE, SETTLE, MONITOR.
- IDLE:
  - On an edge with sample_en=1: shadow<=seg_in, run<=1, go SETTLE.
  - cont is latched into the mode register at this edge.
- SETTLE:
  - Each edge with seg_in!=shadow: shadow<=seg_in, run<=1.
  - Each edge with seg_in==shadow: run<=run+1.
  - On the edge where run+1==STABLE_CYCLES, classify shadow and set exactly one of: valid+value update+decode_cnt++, error, or blank.
  - Next state at that edge is MONITOR if the mode bit is 1, else IDLE.
- MONITOR:
  - Idle-watch of the bus.
  - When seg_in!=shadow: shadow<=seg_in, run<=1, go SETTLE. A changed pattern is decoded again; an unchanged one is never re-reported.
  - If the cont input is 0 on any MONITOR edge: go IDLE.
- Latency: with seg_in constant from the sample_en edge E0, the valid/error pulse is high in the cycle after edge E0+(STABLE_CYCLES-1). With the default, that is 4 cycles after sample_en is registered.
- sample_en is ignored while busy; it is not a restart.
- valid and error are never high in the same cycle.
- value changes only together with valid.
- decode_cnt wraps from 2^CNT_W-1 to 0.
- All outputs are registered; there is no combinational path from seg_in to any output.

Test Plan:
- Reset, then pulse sample_en with seg_in=0x5B held -> valid=1 for exactly one cycle, 4 cycles after the sample_en edge; value=3'b010; decode_cnt=1; busy falls with the pulse.
- seg_in=0xE6, sample_en, then toggle seg_in to 0x4F and back to 0xE6 after 2 cycles -> counting restarts; valid arrives 4 cycles after the last change; value=3'b100 (-4).
- seg_in=0x77 stable, sample_en -> error pulse, valid=0, value retains the prior -4, decode_cnt unchanged; then seg_in=0x00 -> blank=1, no pulse.
- cont=1, sequence 0x3F, 0x06, 0x06, 0xCF, each held 6 cycles -> three valid pulses with values 0, 1, -3; decode_cnt +3; busy stays high; drop cont -> IDLE on the next edge.
- Assert reset_n=0 for one cycle mid-SETTLE (run=2) -> all outputs 0 immediately (async); no pulse follows; new sample_en works normally.
- Run 256 valid decodes in cont mode -> decode_cnt wraps to 0; sample_en pulses while busy -> ignored.
